taxi_meter_core: RTL
====================

// Module: taxi_meter_core
// PURPOSE
//  Parametrised fare engine for the taxi-pricing project: trip FSM, metre/km odometer,
//  tiered per-km pricing, per-minute waiting charge, saturating N-digit BCD fare and
//  running shift total. Sits between debounced buttons/switches and the display mux.
//  Unlike the first meter, it has clean trip states, configurable tariff and overflow flags.
// PARAMETERS
//  DIGITS     5           fare BCD digits, LSD = 0.1 currency unit (total has DIGITS+1)
//  BASE_FARE  100         flag-fall in 0.1 units, charged at trip start (10.0)
//  BASE_KM    3           km covered by BASE_FARE
//  TIER_KM    10          last km billed at RATE1; beyond it RATE2
//  RATE1      24          0.1 units per km, BASE_KM < km <= TIER_KM (2.4)
//  RATE2      36          0.1 units per km, km > TIER_KM (3.6)
//  WAIT_RATE  5           0.1 units per full waiting minute (0.5)
//  M_DIV      125000      CLK cycles per metre travelled
//  SEC_DIV    50000000    CLK cycles per second
// PORTS
//  CLK          in   1             system clock
//  RST_N        in   1             reset, active low
//  go_i         in   1             1-cycle pulse, debounced: start / end trip
//  wait_i       in   1             level: taxi stopped in traffic (SW0 equivalent)
//  clr_total_i  in   1             1-cycle pulse: zero shift total
//  fare_bcd     out  4*DIGITS      current/last trip fare, packed BCD
//  total_bcd    out  4*(DIGITS+1)  sum of billed fares, packed BCD
//  km_o         out  16            whole km of current trip, binary, saturating
//  state_o      out  2             00 IDLE, 01 HIRED, 10 WAITING, 11 BILLED
//  ovf_o        out  2             [0] fare saturated (sticky), [1] total saturated (sticky)
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low. RST_N low: all outputs/regs 0, IDLE.
//  IDLE: fare 0. go_i -> HIRED, fare := BASE_FARE, metre/km/second/minute counters := 0,
//   ovf_o[0] := 0.
//  HIRED: metre prescaler counts; wrap (M_DIV-1 -> 0) increments metre 0..999.
//   Metre 999->0 increments km; new km > BASE_KM adds RATE1 if new km <= TIER_KM, else RATE2.
//   Fare changes on the same edge as the km increment. wait_i=1 -> WAITING.
//  WAITING: metre prescaler frozen (value kept); second prescaler and seconds 0..59 run;
//   59->0 adds WAIT_RATE. wait_i=0 -> HIRED; seconds/second prescaler kept (cumulative).
//  go_i in HIRED/WAITING -> BILLED: fare frozen; total += fare on the next edge.
//  BILLED: fare held; go_i -> HIRED (new trip, as from IDLE). wait_i ignored.
//  Priority: go_i beats a same-cycle km/minute charge (charge discarded, not deferred).
//  clr_total_i: total := 0, ovf_o[1] := 0; if coincident with the billing add, total := fare.
//  Exactly one addend per cycle; adder is digit-serial-free, single-cycle combinational.
//  Saturation: fare sticks at all 9s and sets ovf_o[0]; total sticks at all 9s, ovf_o[1].
//  km_o saturates at 16'hFFFF; charges continue at RATE2.
//  Parameters converted to BCD at elaboration; RATE*/WAIT_RATE < 100, BASE_FARE < 10^DIGITS.
//  wait_i is used as a level sampled each CLK; go_i/clr_total_i must already be 1-cycle.
// STRUCTURE
//  Package taxi_pkg: state enum (IDLE/HIRED/WAITING/BILLED), to_bcd constant function,
//   BCD digit width constant.
//  Sub-module bcd_add_sat #(N): N-digit BCD + 2-digit BCD addend, saturating, carry-out
//   flag; instantiated twice (fare with N=DIGITS, total with N=DIGITS+1 and fare addend
//   widened). Prescalers, counters and FSM stay in taxi_meter_core.
// TESTING  (bench uses M_DIV=2, SEC_DIV=2 unless noted)
//  1 RST_N low mid-trip at km 5 -> state_o=00, fare_bcd=0, km_o=0, ovf_o=0 immediately.
//  2 go_i, run 4 km -> fare 010.0 through km 3, 012.4 at km 4 edge, state_o=01.
//  3 continue to km 11 -> 026.8 at km 10, 030.4 at km 11 (RATE2 step).
//  4 wait_i=1 for 130 s -> +0.5 at 60 s and 120 s, km_o frozen; wait_i=0 resumes metres.
//  5 bill 030.4, new trip, bill 010.0 -> total 0040.4; clr_total_i on 2nd bill cycle -> 0010.0.
//  6 DIGITS=3, BASE_FARE=990, run 1 km past BASE_KM -> fare 99.9, ovf_o[0]=1 until next go.

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared types and elaboration-time helpers for the taxi fare engine.
package taxi_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_W = 4;

  // Trip state; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HIRED   = 2'b01,
    ST_WAITING = 2'b10,
    ST_BILLED  = 2'b11
  } trip_state_e;

  // Binary to 8-digit packed BCD, used only on parameters at elaboration.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[BCD_W*i +: BCD_W] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/taxi_meter_core_if.sv
// Button/switch inputs and display-side outputs of the fare engine.
//
// Signalling: there is no valid/ready pair. go_i and clr_total_i are
// single-cycle strobes (already debounced and edge-detected upstream) and
// each high cycle is one request; wait_i is a level sampled every clock.
// All outputs are registered and always valid.
interface taxi_meter_core_if
  import taxi_pkg::*;
#(
  parameter int DIGITS = 5
);
  logic                          go_i;
  logic                          wait_i;
  logic                          clr_total_i;
  logic [BCD_W*DIGITS-1:0]       fare_bcd;
  logic [BCD_W*(DIGITS+1)-1:0]   total_bcd;
  logic [15:0]                   km_o;
  logic [1:0]                    state_o;
  logic [1:0]                    ovf_o;

  // Master drives the controls (button logic / testbench).
  modport master (
    output go_i, wait_i, clr_total_i,
    input  fare_bcd, total_bcd, km_o, state_o, ovf_o
  );

  // Slave is the fare engine itself.
  modport slave (
    input  go_i, wait_i, clr_total_i,
    output fare_bcd, total_bcd, km_o, state_o, ovf_o
  );
endinterface

// File: rtl/bcd_add_sat.sv
// N-digit packed BCD adder with an M-digit addend (M <= N).
// A carry out of the top digit clamps the sum to all nines and raises sat_o.
module bcd_add_sat
  import taxi_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 2
) (
  input  logic [BCD_W*N-1:0] a_i,
  input  logic [BCD_W*M-1:0] b_i,
  output logic [BCD_W*N-1:0] sum_o,
  output logic               sat_o
);

  logic [BCD_W*N-1:0] b_wide;
  logic [BCD_W*N-1:0] raw;
  logic [BCD_W:0]     dsum;
  logic               carry;

  // Ripple decimal add, digit by digit, then clamp on final carry.
  always_comb begin
    b_wide = '0;
    b_wide[BCD_W*M-1:0] = b_i;
    raw    = '0;
    carry  = 1'b0;
    dsum   = '0;
    for (int i = 0; i < N; i++) begin
      dsum = {1'b0, a_i[BCD_W*i +: BCD_W]} + {1'b0, b_wide[BCD_W*i +: BCD_W]}
           + {{BCD_W{1'b0}}, carry};
      if (dsum > 5'd9) begin
        // dsum - 10 taken modulo 16
        raw[BCD_W*i +: BCD_W] = dsum[BCD_W-1:0] + 4'd6;
        carry = 1'b1;
      end else begin
        raw[BCD_W*i +: BCD_W] = dsum[BCD_W-1:0];
        carry = 1'b0;
      end
    end
    sat_o = carry;
    sum_o = carry ? {N{4'h9}} : raw;
  end

endmodule

// File: rtl/taxi_meter_core.sv
// Taxi fare engine: trip FSM, metre/km odometer, tiered per-km pricing,
// per-minute waiting charge, saturating BCD fare and shift total.
module taxi_meter_core
  import taxi_pkg::*;
#(
  parameter int DIGITS    = 5,
  parameter int BASE_FARE = 100,
  parameter int BASE_KM   = 3,
  parameter int TIER_KM   = 10,
  parameter int RATE1     = 24,
  parameter int RATE2     = 36,
  parameter int WAIT_RATE = 5,
  parameter int M_DIV     = 125000,
  parameter int SEC_DIV   = 50000000
) (
  input  logic                CLK,
  input  logic                RST_N,
  taxi_meter_core_if.slave    bus
);

  localparam int FW = BCD_W * DIGITS;
  localparam int TW = BCD_W * (DIGITS + 1);
  localparam int MW = (M_DIV > 1) ? $clog2(M_DIV) : 1;
  localparam int SW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

  localparam logic [MW-1:0] M_LAST    = MW'(M_DIV - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(SEC_DIV - 1);
  localparam logic [15:0]   BASE_KM16 = 16'(BASE_KM);
  localparam logic [15:0]   TIER_KM16 = 16'(TIER_KM);

  // Tariff constants in BCD, fixed at elaboration.
  localparam logic [FW-1:0] BASE_BCD  = FW'(to_bcd(BASE_FARE));
  localparam logic [7:0]    RATE1_BCD = 8'(to_bcd(RATE1));
  localparam logic [7:0]    RATE2_BCD = 8'(to_bcd(RATE2));
  localparam logic [7:0]    WAIT_BCD  = 8'(to_bcd(WAIT_RATE));

  trip_state_e   state_q, state_d;
  logic [MW-1:0] m_pre_q, m_pre_d;
  logic [9:0]    metre_q, metre_d;
  logic [15:0]   km_q, km_d;
  logic [SW-1:0] s_pre_q, s_pre_d;
  logic [5:0]    sec_q, sec_d;
  logic [FW-1:0] fare_q, fare_d;
  logic [TW-1:0] total_q, total_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          bill_q, bill_d;

  logic          m_wrap, km_evt, km_charge, s_wrap, min_evt;
  logic [15:0]   km_next;
  logic [7:0]    rate_bcd, add_val;
  logic [FW-1:0] fare_sum;
  logic          fare_sat;
  logic [TW-1:0] total_sum;
  logic          total_sat;

  // Travel and waiting tick events, plus the single fare addend they select.
  always_comb begin
    m_wrap    = (state_q == ST_HIRED) && (m_pre_q == M_LAST);
    km_evt    = m_wrap && (metre_q == 10'd999);
    km_next   = (km_q == 16'hFFFF) ? km_q : km_q + 16'd1;
    // Once km_o is pinned at its maximum, every further km bills at RATE2.
    km_charge = km_evt && ((km_q == 16'hFFFF) || (km_next > BASE_KM16));
    rate_bcd  = ((km_q == 16'hFFFF) || (km_next > TIER_KM16)) ? RATE2_BCD : RATE1_BCD;
    s_wrap    = (state_q == ST_WAITING) && (s_pre_q == S_LAST);
    min_evt   = s_wrap && (sec_q == 6'd59);
    add_val   = min_evt ? WAIT_BCD : rate_bcd;
  end

  bcd_add_sat #(.N(DIGITS), .M(2)) u_fare_add (
    .a_i   (fare_q),
    .b_i   (add_val),
    .sum_o (fare_sum),
    .sat_o (fare_sat)
  );

  bcd_add_sat #(.N(DIGITS + 1), .M(DIGITS)) u_total_add (
    .a_i   (total_q),
    .b_i   (fare_q),
    .sum_o (total_sum),
    .sat_o (total_sat)
  );

  // Next-state logic: shift total, then the trip FSM with its counters.
  always_comb begin
    state_d = state_q;
    m_pre_d = m_pre_q;
    metre_d = metre_q;
    km_d    = km_q;
    s_pre_d = s_pre_q;
    sec_d   = sec_q;
    fare_d  = fare_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    bill_d  = 1'b0;

    // The billed fare lands in the total one edge after go_i ends the trip.
    if (bus.clr_total_i) begin
      total_d  = bill_q ? TW'(fare_q) : '0;
      ovf_d[1] = 1'b0;
    end else if (bill_q) begin
      total_d = total_sum;
      if (total_sat) ovf_d[1] = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_BILLED: begin
        if (bus.go_i) begin
          state_d  = ST_HIRED;
          fare_d   = BASE_BCD;
          m_pre_d  = '0;
          metre_d  = '0;
          km_d     = '0;
          s_pre_d  = '0;
          sec_d    = '0;
          ovf_d[0] = 1'b0;
        end
      end
      ST_HIRED: begin
        // go_i wins: any charge due this cycle is dropped.
        if (bus.go_i) begin
          state_d = ST_BILLED;
          bill_d  = 1'b1;
        end else begin
          m_pre_d = m_wrap ? '0 : m_pre_q + 1'b1;
          if (m_wrap) metre_d = (metre_q == 10'd999) ? '0 : metre_q + 10'd1;
          if (km_evt) km_d = km_next;
          if (km_charge) begin
            fare_d = fare_sum;
            if (fare_sat) ovf_d[0] = 1'b1;
          end
          if (bus.wait_i) state_d = ST_WAITING;
        end
      end
      ST_WAITING: begin
        // Metre prescaler holds; seconds accumulate across waiting spells.
        if (bus.go_i) begin
          state_d = ST_BILLED;
          bill_d  = 1'b1;
        end else begin
          s_pre_d = s_wrap ? '0 : s_pre_q + 1'b1;
          if (s_wrap) sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
          if (min_evt) begin
            fare_d = fare_sum;
            if (fare_sat) ovf_d[0] = 1'b1;
          end
          if (!bus.wait_i) state_d = ST_HIRED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      m_pre_q <= '0;
      metre_q <= '0;
      km_q    <= '0;
      s_pre_q <= '0;
      sec_q   <= '0;
      fare_q  <= '0;
      total_q <= '0;
      ovf_q   <= '0;
      bill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_pre_q <= m_pre_d;
      metre_q <= metre_d;
      km_q    <= km_d;
      s_pre_q <= s_pre_d;
      sec_q   <= sec_d;
      fare_q  <= fare_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      bill_q  <= bill_d;
    end
  end

  assign bus.fare_bcd  = fare_q;
  assign bus.total_bcd = total_q;
  assign bus.km_o      = km_q;
  assign bus.state_o   = state_q;
  assign bus.ovf_o     = ovf_q;

endmodule
